hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the load-only RAW hazard detector.
- Sits between decode and execute of the N-lane VLIW pipeline and issues one global stall to all lanes.
- Tracks a per-architectural-register countdown of cycles until each in-flight result is forwardable, so variable-latency producers are handled (load, multiply, future long ops).
- Adds x0 immunity, WAW protection, flush and a stall performance counter.

Parameters:
- NUM_LANES, 3, issue lanes per bundle (ixu1, ixu2, lsu)
- NUM_SRC, 2, source operands per lane
- NUM_REGS, 32, architectural registers; index 0 is hard-wired zero
- REG_W, 5, register index width, equal to clog2(NUM_REGS)
- LAT_W, 3, latency field width; max latency 2**LAT_W-1
- CNT_W, 16, stall cycle counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_in  in  1  pipeline flush (branch/exception); discards decode bundle and all pending entries
- dc_valid_in  in  1  decode bundle valid
- dc_rs_in  in  NUM_LANES*NUM_SRC*REG_W  source indices; lane l, src s at slice (l*NUM_SRC+s)*REG_W
- dc_rs_used_in  in  NUM_LANES*NUM_SRC  source actually read
- dc_rd_in  in  NUM_LANES*REG_W  destination index per lane
- dc_rd_we_in  in  NUM_LANES  lane writes rd
- dc_lat_in  in  NUM_LANES*LAT_W  extra cycles before the lane result is forwardable; 0 means ALU/fully forwarded, 1 means load
- stall_out  out  1  hold decode/fetch and insert a bubble into execute on all lanes
- busy_mask_out  out  NUM_REGS  bit r set when cnt[r] != 0 (debug)
- stall_cycles_out  out  CNT_W  saturating count of stalled cycles

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Source hazard: a (lane, src) pair hazards when dc_valid_in, used=1, rs!=0 and cnt[rs]!=0.
- WAW hazard: a lane hazards when dc_valid_in, we=1, rd!=0 and cnt[rd] > lat. This keeps the older long-latency write from landing last.
- stall_out:
  - equals the OR of all hazards, computed combinationally from registered cnt and decode inputs.
  - forced 0 when rst or flush_in.
  - does not depend on itself.
- Issue: issue = dc_valid_in && !stall_out && !flush_in.
- Per register r, every rising edge, in priority order:
  - rst or flush_in: cnt[r] <= 0.
  - issue and some lane writes r with lat>0: cnt[r] <= the max lat among those lanes. The set value is not decremented in the same cycle. Duplicate rd in one bundle is legal and takes the max.
  - issue and some lane writes r with lat=0: cnt[r] <= 0.
  - otherwise: cnt[r] <= cnt[r]-1 if nonzero, else hold.
- Timing: a producer issued at cycle t with lat L makes a dependent in decode at t+1 stall exactly L cycles (it sees L, L-1, …, 1). The dependent issues at t+L+1. A load (L=1) gives exactly one bubble, matching the previous block.
- Intra-bundle reads of a sibling lane's rd are not hazards (VLIW read-old-value semantics).
- rd=0 writes are never recorded. rs=0 never stalls.
- stall_cycles_out:
  - increments by 1 each edge where stall_out=1.
  - saturates at all-ones.
  - cleared only by rst; flush does not clear it.
- Reset values: all cnt 0, stall_out 0, busy_mask_out 0, stall_cycles_out 0.
- Reset or flush mid-countdown: everything clears in one edge, and the bundle presented next cycle sees no hazard.

Decomposition:
- Package hazard_pkg holds:
  - NUM_REGS, REG_W and LAT_W defaults
  - typedef reg_idx_t = logic [REG_W-1:0]
  - typedef lat_t = logic [LAT_W-1:0]
  - LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 2
- One natural sub-module: scoreboard_entry. It holds one register's counter with set/max/decrement/clear logic and is instantiated NUM_REGS-1 times via generate.
- Hazard compare and OR-reduce stay in the top level.

Test Plan:
- Load-use: lsu issues load to x5 (lat 1); next bundle ixu1 reads x5 → stall_out=1 for exactly 1 cycle, issues next; stall_cycles_out=1.
- x0 immunity: load to x0 lat 1, then bundle reading x0 on all lanes → stall_out never asserts, busy_mask_out stays 0.
- Long latency: mul to x7 with lat 3; consumer of x7 in next bundle → stall for 3 cycles while busy_mask_out[7] stays set, then issue; an independent bundle on the same path would also be held (global stall).
- WAW and duplicates:
  - lat-3 write to x9, then a lat-1 write to x9 → stall until cnt[9] ≤ 1 (2 stalls).
  - A single bundle with two lanes writing x4 at lat 1 and lat 2 → cnt[4]=2.
- Flush mid-pending: lat-3 write to x12, flush_in asserted next cycle → stall_out 0 that cycle, cnt cleared; following bundle reading x12 issues with no stall. Repeat with rst → all outputs 0.
- Saturation: with CNT_W=4, hold a continuous hazard for 20 cycles → stall_cycles_out stops at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, types and latency codes for the hazard scoreboard
package hazard_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int LAT_W    = 3;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [LAT_W-1:0] lat_t;

    localparam lat_t LAT_ALU  = 3'd0;
    localparam lat_t LAT_LOAD = 3'd1;
    localparam lat_t LAT_MUL  = 3'd2;

endpackage

// File: rtl/scoreboard_entry.sv
// rtl/scoreboard_entry.sv - countdown for one architectural register until its result is forwardable
module scoreboard_entry
    import hazard_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int CW        = LAT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    issue,
    input  logic [NUM_LANES-1:0]    hit,
    input  logic [NUM_LANES*CW-1:0] lat,
    output logic [CW-1:0]           cnt
);

    logic [CW-1:0] max_lat;
    logic          any_hit;

    // Duplicate destinations in one bundle take the longest latency.
    always_comb begin
        max_lat = '0;
        any_hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (hit[l]) begin
                any_hit = 1'b1;
                if (lat[l*CW +: CW] > max_lat) begin
                    max_lat = lat[l*CW +: CW];
                end
            end
        end
    end

    // A fresh write (lat 0 included) overrides the running countdown.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (issue && any_hit) begin
            cnt <= max_lat;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - global-stall RAW/WAW scoreboard between decode and execute of the VLIW pipe
module hazard_scoreboard #(
    parameter int NUM_LANES = 3,
    parameter int NUM_SRC   = 2,
    parameter int NUM_REGS  = hazard_pkg::NUM_REGS,
    parameter int REG_W     = hazard_pkg::REG_W,
    parameter int LAT_W     = hazard_pkg::LAT_W,
    parameter int CNT_W     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_in,
    input  logic                                dc_valid_in,
    input  logic [NUM_LANES*NUM_SRC*REG_W-1:0]  dc_rs_in,
    input  logic [NUM_LANES*NUM_SRC-1:0]        dc_rs_used_in,
    input  logic [NUM_LANES*REG_W-1:0]          dc_rd_in,
    input  logic [NUM_LANES-1:0]                dc_rd_we_in,
    input  logic [NUM_LANES*LAT_W-1:0]          dc_lat_in,
    output logic                                stall_out,
    output logic [NUM_REGS-1:0]                 busy_mask_out,
    output logic [CNT_W-1:0]                    stall_cycles_out
);

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic                           hazard;
    logic                           issue;
    logic [REG_W-1:0]               rs_v;
    logic [REG_W-1:0]               rd_v;
    logic [LAT_W-1:0]               lat_v;
    logic [CNT_W-1:0]               stall_cnt;

    // Sibling-lane writes in the same bundle are invisible here: reads see old values.
    always_comb begin
        hazard = 1'b0;
        rs_v   = '0;
        rd_v   = '0;
        lat_v  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                rs_v = dc_rs_in[(l*NUM_SRC+s)*REG_W +: REG_W];
                if (dc_rs_used_in[l*NUM_SRC+s] && rs_v != '0 && cnt[rs_v] != '0) begin
                    hazard = 1'b1;
                end
            end
            rd_v  = dc_rd_in[l*REG_W +: REG_W];
            lat_v = dc_lat_in[l*LAT_W +: LAT_W];
            // An older write still outstanding longer than this one would land last.
            if (dc_rd_we_in[l] && rd_v != '0 && cnt[rd_v] > lat_v) begin
                hazard = 1'b1;
            end
        end
    end

    assign stall_out = dc_valid_in && !rst && !flush_in && hazard;
    assign issue     = dc_valid_in && !stall_out && !flush_in;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic [NUM_LANES-1:0] hit;
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_hit
            assign hit[l] = dc_rd_we_in[l] && (dc_rd_in[l*REG_W +: REG_W] == REG_W'(r));
        end
        scoreboard_entry #(
            .NUM_LANES (NUM_LANES),
            .CW        (LAT_W)
        ) u_entry (
            .clk   (clk),
            .rst   (rst),
            .flush (flush_in),
            .issue (issue),
            .hit   (hit),
            .lat   (dc_lat_in),
            .cnt   (cnt[r])
        );
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
        assign busy_mask_out[r] = |cnt[r];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_out && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cycles_out = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NL  = 3;
    localparam int NS  = 2;
    localparam int NR  = 32;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic valid;
    logic [NL-1:0][NS-1:0][4:0] rs_a;
    logic [NL*NS-1:0]           used;
    logic [NL-1:0][4:0]         rd_a;
    logic [NL-1:0]              we;
    logic [NL-1:0][2:0]         lat_a;
    logic                       stall;
    logic [NR-1:0]              busy;
    logic [CW-1:0]              sc_out;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_LANES (NL),
        .NUM_SRC   (NS),
        .NUM_REGS  (NR),
        .REG_W     (5),
        .LAT_W     (3),
        .CNT_W     (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_in         (flush),
        .dc_valid_in      (valid),
        .dc_rs_in         (rs_a),
        .dc_rs_used_in    (used),
        .dc_rd_in         (rd_a),
        .dc_rd_we_in      (we),
        .dc_lat_in        (lat_a),
        .stall_out        (stall),
        .busy_mask_out    (busy),
        .stall_cycles_out (sc_out)
    );

    typedef struct packed {
        logic          stall;
        logic [NR-1:0] busy;
        logic [CW-1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: absolute cycle at which each register's result becomes forwardable.
    int now = 0;
    int ready[NR];
    int sc_model = 0;

    function automatic int rem(int r);
        if (r == 0) return 0;
        return (ready[r] > now) ? ready[r] - now : 0;
    endfunction

    task automatic clear_in();
        valid = 1'b0; flush = 1'b0;
        rs_a = '0; used = '0; rd_a = '0; we = '0; lat_a = '0;
    endtask

    task automatic set_wr(input int l, input int r, input int lat);
        valid = 1'b1; we[l] = 1'b1; rd_a[l] = 5'(r); lat_a[l] = 3'(lat);
    endtask

    task automatic set_rd(input int l, input int s, input int r);
        valid = 1'b1; used[l*NS+s] = 1'b1; rs_a[l][s] = 5'(r);
    endtask

    task automatic cyc();
        bit   haz;
        exp_t e;
        int   best;
        haz = 0;
        for (int l = 0; l < NL; l++) begin
            for (int s = 0; s < NS; s++) begin
                if (used[l*NS+s] && rs_a[l][s] != 0 && rem(int'(rs_a[l][s])) != 0) haz = 1;
            end
            if (we[l] && rd_a[l] != 0 && rem(int'(rd_a[l])) > int'(lat_a[l])) haz = 1;
        end
        e.stall = valid && !rst && !flush && haz;
        for (int r = 0; r < NR; r++) e.busy[r] = (rem(r) != 0);
        e.sc = CW'(sc_model);
        exp_q.push_back(e);
        if (rst) begin
            for (int r = 0; r < NR; r++) ready[r] = 0;
            sc_model = 0;
        end else begin
            if (e.stall && sc_model < SAT) sc_model++;
            if (flush) begin
                for (int r = 0; r < NR; r++) ready[r] = 0;
            end else if (valid && !e.stall) begin
                for (int r = 1; r < NR; r++) begin
                    best = -1;
                    for (int l = 0; l < NL; l++) begin
                        if (we[l] && int'(rd_a[l]) == r && int'(lat_a[l]) > best) best = int'(lat_a[l]);
                    end
                    if (best >= 0) ready[r] = now + 1 + best;
                end
            end
        end
        now++;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (stall !== e.stall) begin
                    bad++;
                    $display("FAIL stall t=%0t got=%b want=%b", $time, stall, e.stall);
                end
                total++;
                if (busy !== e.busy) begin
                    bad++;
                    $display("FAIL busy_mask t=%0t got=%h want=%h", $time, busy, e.busy);
                end
                total++;
                if (sc_out !== e.sc) begin
                    bad++;
                    $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, sc_out, e.sc);
                end
            end
        end
    end

    initial begin : stim
        for (int r = 0; r < NR; r++) ready[r] = 0;
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        rst = 1'b0;
        cyc();

        // load-use
        clear_in(); set_wr(2, 5, LAT_LOAD); cyc();
        clear_in(); set_rd(0, 0, 5); cyc(); cyc();
        clear_in(); cyc();

        // x0 immunity
        set_wr(2, 0, LAT_LOAD); cyc();
        clear_in();
        for (int l = 0; l < NL; l++) for (int s = 0; s < NS; s++) set_rd(l, s, 0);
        cyc(); cyc();

        // long latency with global hold
        clear_in(); set_wr(0, 7, 3); cyc();
        clear_in(); set_rd(0, 0, 7); set_rd(1, 0, 2); repeat (5) cyc();

        // WAW then duplicate destinations
        clear_in(); set_wr(0, 9, 3); cyc();
        clear_in(); set_wr(2, 9, 1); repeat (4) cyc();
        clear_in(); set_wr(1, 4, 1); set_wr(2, 4, 2); cyc();
        clear_in(); repeat (3) cyc();

        // flush mid-countdown
        set_wr(0, 12, 3); cyc();
        clear_in(); flush = 1'b1; set_rd(0, 0, 12); cyc();
        flush = 1'b0; cyc();

        // reset mid-countdown
        clear_in(); set_wr(0, 12, 3); cyc();
        clear_in(); rst = 1'b1; set_rd(0, 0, 12); cyc();
        rst = 1'b0; cyc();

        // stall counter saturation
        for (int k = 0; k < 3; k++) begin
            clear_in(); set_wr(0, 3, 7); cyc();
            clear_in(); set_rd(0, 0, 3); repeat (8) cyc();
        end

        // random bundles over a small register window to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            clear_in();
            rst   = ($urandom % 64) == 0;
            flush = ($urandom % 20) == 0;
            valid = ($urandom % 4) != 0;
            for (int l = 0; l < NL; l++) begin
                we[l]    = $urandom % 2;
                rd_a[l]  = 5'($urandom % 8);
                lat_a[l] = 3'(($urandom % 4 == 0) ? $urandom % 8 : $urandom % 3);
                for (int s = 0; s < NS; s++) begin
                    used[l*NS+s] = ($urandom % 5) < 3;
                    rs_a[l][s]   = 5'($urandom % 8);
                end
            end
            cyc();
        end

        clear_in();
        rst = 1'b0;
        cyc(); cyc();
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
